// File: rtl/amplitude_selector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : amplitude_selector
// Description : DDS function generator; phase accumulator, 8-shape waveform
//               synthesis and power-of-two amplitude scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module amplitude_selector #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    output logic             cout4,
    input  logic [12:0]      sw,
    input  logic             clk,
    input  logic             init,
    output logic             cout5,
    output logic             cout6,
    output logic             cout7,
    output logic             cout0,
    output logic             cout1,
    output logic             cout2,
    output logic             cout3,
    output logic             freq_sel,
    output logic [OUT_W-1:0] wave,
    input  logic             rst
);

    localparam logic [7:0] C_MID = 8'd128;

    logic [ACC_W-1:0] r_acc;
    logic             r_freq_sel;
    logic [OUT_W-1:0] r_wave;

    logic [ACC_W:0]   w_sum;
    logic [7:0]       w_phase;
    logic [7:0]       w_inv;
    logic [5:0]       w_q;
    logic [5:0]       w_idx;
    logic             w_peak;
    logic [6:0]       w_lut;
    logic [6:0]       w_amp;
    logic [7:0]       w_sine;
    logic [7:0]       w_rect;
    logic [7:0]       w_raw;
    logic [7:0]       w_scaled;

    assign w_sum   = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, sw[7:0]};
    assign w_phase = r_acc[ACC_W-1 -: 8];
    assign w_inv   = ~w_phase;

    // Odd quadrants mirror the table (index 64-q); q=0 there is the crest,
    // which falls just outside the 64-entry table.
    assign w_q    = w_phase[5:0];
    assign w_idx  = w_phase[6] ? (6'd0 - w_q) : w_q;
    assign w_peak = w_phase[6] && (w_q == 6'd0);
    assign w_amp  = w_peak ? 7'd127 : w_lut;
    assign w_sine = w_phase[7] ? (C_MID - {1'b0, w_amp}) : (C_MID + {1'b0, w_amp});
    // |sine-128|*2 peaks at 254, so the clip to 255 never engages.
    assign w_rect = {w_amp, 1'b0};

    always_comb begin
        w_lut = 7'd0;
        case (w_idx)
            6'd0:  w_lut = 7'd0;   6'd1:  w_lut = 7'd3;   6'd2:  w_lut = 7'd6;   6'd3:  w_lut = 7'd9;
            6'd4:  w_lut = 7'd12;  6'd5:  w_lut = 7'd16;  6'd6:  w_lut = 7'd19;  6'd7:  w_lut = 7'd22;
            6'd8:  w_lut = 7'd25;  6'd9:  w_lut = 7'd28;  6'd10: w_lut = 7'd31;  6'd11: w_lut = 7'd34;
            6'd12: w_lut = 7'd37;  6'd13: w_lut = 7'd40;  6'd14: w_lut = 7'd43;  6'd15: w_lut = 7'd46;
            6'd16: w_lut = 7'd49;  6'd17: w_lut = 7'd51;  6'd18: w_lut = 7'd54;  6'd19: w_lut = 7'd57;
            6'd20: w_lut = 7'd60;  6'd21: w_lut = 7'd63;  6'd22: w_lut = 7'd65;  6'd23: w_lut = 7'd68;
            6'd24: w_lut = 7'd71;  6'd25: w_lut = 7'd73;  6'd26: w_lut = 7'd76;  6'd27: w_lut = 7'd78;
            6'd28: w_lut = 7'd81;  6'd29: w_lut = 7'd83;  6'd30: w_lut = 7'd85;  6'd31: w_lut = 7'd88;
            6'd32: w_lut = 7'd90;  6'd33: w_lut = 7'd92;  6'd34: w_lut = 7'd94;  6'd35: w_lut = 7'd96;
            6'd36: w_lut = 7'd98;  6'd37: w_lut = 7'd100; 6'd38: w_lut = 7'd102; 6'd39: w_lut = 7'd104;
            6'd40: w_lut = 7'd106; 6'd41: w_lut = 7'd107; 6'd42: w_lut = 7'd109; 6'd43: w_lut = 7'd111;
            6'd44: w_lut = 7'd112; 6'd45: w_lut = 7'd113; 6'd46: w_lut = 7'd115; 6'd47: w_lut = 7'd116;
            6'd48: w_lut = 7'd117; 6'd49: w_lut = 7'd118; 6'd50: w_lut = 7'd120; 6'd51: w_lut = 7'd121;
            6'd52: w_lut = 7'd122; 6'd53: w_lut = 7'd122; 6'd54: w_lut = 7'd123; 6'd55: w_lut = 7'd124;
            6'd56: w_lut = 7'd125; 6'd57: w_lut = 7'd125; 6'd58: w_lut = 7'd126; 6'd59: w_lut = 7'd126;
            6'd60: w_lut = 7'd126; 6'd61: w_lut = 7'd127; 6'd62: w_lut = 7'd127; 6'd63: w_lut = 7'd127;
            default: w_lut = 7'd0;
        endcase
    end

    always_comb begin
        w_raw = C_MID;
        case (sw[10:8])
            3'b000: w_raw = w_phase[7] ? 8'd0 : 8'd255;
            3'b001: w_raw = w_phase;
            3'b010: w_raw = w_phase[7] ? {w_inv[6:0], 1'b0} : {w_phase[6:0], 1'b0};
            3'b011: w_raw = w_inv;
            3'b100: w_raw = w_sine;
            3'b101: w_raw = w_rect;
            3'b110: w_raw = w_phase[7] ? C_MID : w_sine;
            3'b111: w_raw = C_MID;
            default: w_raw = C_MID;
        endcase
    end

    assign w_scaled = w_raw >> sw[12:11];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_freq_sel <= 1'b0;
            r_wave     <= '0;
        end else begin
            if (init) begin
                r_acc      <= w_sum[ACC_W-1:0];
                r_freq_sel <= w_sum[ACC_W];
            end else begin
                r_freq_sel <= 1'b0;
            end
            r_wave <= OUT_W'(w_scaled);
        end
    end

    assign {cout7, cout6, cout5, cout4, cout3, cout2, cout1, cout0} = w_phase;
    assign freq_sel = r_freq_sel;
    assign wave     = r_wave;

endmodule
`default_nettype wire

// File: tb/tb_amplitude_selector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_amplitude_selector
// Description : Randomised scoreboard bench for amplitude_selector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amplitude_selector;

    logic        clk;
    logic        rst;
    logic        init;
    logic [12:0] sw;
    logic        cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7;
    logic        freq_sel;
    logic [7:0]  wave;
    logic [7:0]  w_cout;

    typedef struct {
        int phase;
        int fs;
        int wave;
    } exp_t;

    exp_t sb[$];
    int   m_acc;
    int   n_vec;
    int   n_err;

    amplitude_selector #(.ACC_W(16), .OUT_W(8)) dut (
        .cout4(cout4), .sw(sw), .clk(clk), .init(init),
        .cout5(cout5), .cout6(cout6), .cout7(cout7),
        .cout0(cout0), .cout1(cout1), .cout2(cout2), .cout3(cout3),
        .freq_sel(freq_sel), .wave(wave), .rst(rst)
    );

    assign w_cout = {cout7, cout6, cout5, cout4, cout3, cout2, cout1, cout0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int ref_sine(input int p);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
        return $rtoi(v + 0.5);
    endfunction

    function automatic int ref_raw(input int p, input int sel);
        int s;
        int r;
        s = ref_sine(p);
        case (sel)
            0: return (p < 128) ? 255 : 0;
            1: return p;
            2: return (p < 128) ? 2 * p : 2 * (255 - p);
            3: return 255 - p;
            4: return s;
            5: begin
                r = (s >= 128) ? (s - 128) * 2 : (128 - s) * 2;
                return (r > 255) ? 255 : r;
            end
            6: return (p < 128) ? s : 128;
            default: return 128;
        endcase
    endfunction

    // One clock of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic drive(input logic in_init, input logic [12:0] in_sw);
        exp_t e;
        int   p_old;
        int   sum;
        @(negedge clk);
        init  = in_init;
        sw    = in_sw;
        p_old = m_acc / 256;
        if (in_init) begin
            sum   = m_acc + int'(in_sw[7:0]);
            e.fs  = (sum >= 65536) ? 1 : 0;
            m_acc = sum % 65536;
        end else begin
            e.fs = 0;
        end
        e.phase = m_acc / 256;
        e.wave  = ref_raw(p_old, int'(in_sw[10:8])) >> in_sw[12:11];
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; asserts reset between edges and releases it mid-high phase.
    task automatic do_reset();
        #1;
        rst  = 1'b0;
        sw   = 13'($urandom_range(0, 8191));
        init = 1'($urandom_range(0, 1));
        #1;
        chk("rst_async_wave", int'(wave), 0);
        chk("rst_async_cout", int'(w_cout), 0);
        chk("rst_async_fs", int'(freq_sel), 0);
        m_acc = 0;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst_hold_wave", int'(wave), 0);
            chk("rst_hold_cout", int'(w_cout), 0);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_cout", int'(w_cout), e.phase);
                chk("sb_freq_sel", int'(freq_sel), e.fs);
                chk("sb_wave", int'(wave), e.wave);
            end
        end
    end

    initial begin
        int first_wrap;
        int n_wrap;
        int sh;
        logic [12:0] r_sw;
        logic        r_init;

        n_vec = 0;
        n_err = 0;
        m_acc = 0;
        rst   = 1'b0;
        init  = 1'b0;
        sw    = 13'd0;
        @(posedge clk);
        #2;
        do_reset();

        // Triangle, step 50
        for (int k = 1; k <= 6; k++) drive(1'b1, 13'h0232);
        chk("t2_cout_after6", int'(w_cout), 1);
        drive(1'b1, 13'h0232);
        chk("t2_wave_after7", int'(wave), 2);
        first_wrap = 0;
        n_wrap     = 0;
        for (int k = 8; k <= 1320; k++) begin
            drive(1'b1, 13'h0232);
            if (freq_sel) begin
                n_wrap++;
                if (first_wrap == 0) first_wrap = k;
            end
        end
        chk("t3_first_wrap_edge", first_wrap, 1311);
        chk("t3_wrap_pulses", n_wrap, 1);

        // Ramp up to phase 200, then hold and sweep the amplitude shift
        do_reset();
        for (int k = 1; k <= 201; k++) drive(1'b1, {2'b00, 3'b001, 8'd255});
        chk("t4_phase", int'(w_cout), 200);
        for (int s = 0; s < 4; s++) begin
            sh = s;
            drive(1'b0, {2'(sh), 3'b001, 8'd255});
            chk("t4_scaled_wave", int'(wave), 200 >> sh);
            chk("t5_cout_frozen", int'(w_cout), 200);
            chk("t5_fs_low", int'(freq_sel), 0);
        end
        drive(1'b0, {2'b00, 3'b011, 8'd255});
        chk("t5_sel_change", int'(wave), 55);

        // Sine at step 64: p=64 and p=192 appear on wave one edge after cout
        do_reset();
        for (int k = 1; k <= 1024; k++) begin
            drive(1'b1, {2'b00, 3'b100, 8'd64});
            if (k == 257) chk("t6_sine_p64", int'(wave), 255);
            if (k == 769) chk("t6_sine_p192", int'(wave), 1);
        end

        // Randomised run
        r_sw = 13'($urandom_range(0, 8191));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) r_sw = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 15) == 0) r_sw[7:0] = 8'd0;
            r_init = ($urandom_range(0, 7) != 0);
            drive(r_init, r_sw);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        @(posedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
